// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed, checksummed byte stream and writes it to RAM as 16-bit words.
// Ports:
//   clk, reset (async, active-low)
//   start                          begin a load (honoured only when idle, done or in error)
//   rx_data/rx_valid/rx_ready      byte stream in; a byte moves when rx_valid && rx_ready
//   mem_addr/mem_data/mem_write    RAM write port, one strobe per word
//   cpu_hold                       held high until an image passes its checksum
//   busy/done/error                load status
//   words_loaded                   words written by the current/last load
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data,
  output logic                  mem_write,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM, DONE, ERR} state_t;
  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d, len_new;
  logic [7:0]            hi_q, hi_d, csum_q, csum_d;
  logic [ADDR_WIDTH:0]   wl_q, wl_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic                  mw_q, mw_d, busy_q, busy_d, done_q, done_d, err_q, err_d, hold_q, hold_d;
  logic                  xfer;
  assign rx_ready     = state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM};
  assign xfer         = rx_valid && rx_ready;
  assign len_new      = {len_q[15:8], rx_data};
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign mem_write    = mw_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
  assign words_loaded = wl_q;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    wl_d    = wl_q;
    addr_d  = addr_q;
    data_d  = data_q;
    // the checksum covers every byte except the checksum byte itself
    if (xfer && state_q != CSUM) csum_d = csum_q + rx_data;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = LEN_HI;
        csum_d  = 8'd0;
        wl_d    = '0;
      end
      LEN_HI: if (xfer) begin
        state_d = LEN_LO;
        len_d   = {rx_data, len_q[7:0]};
      end
      LEN_LO: if (xfer) begin
        len_d   = len_new;
        state_d = (len_new == 16'd0 || 32'(len_new) > (32'd1 << ADDR_WIDTH)) ? ERR : DATA_HI;
      end
      DATA_HI: if (xfer) begin
        state_d = DATA_LO;
        hi_d    = rx_data;
      end
      // address and data are staged here so the write strobe and its payload leave the flops together
      DATA_LO: if (xfer) begin
        state_d = WRITE;
        addr_d  = ADDR_WIDTH'(BASE_ADDR) + wl_q[ADDR_WIDTH-1:0];
        data_d  = {hi_q, rx_data};
      end
      WRITE: begin
        wl_d    = wl_q + 1'b1;
        state_d = (32'(wl_q) + 32'd1 == 32'(len_q)) ? CSUM : DATA_HI;
      end
      CSUM: if (xfer) state_d = (rx_data == csum_q) ? DONE : ERR;
      default: state_d = IDLE;
    endcase
    mw_d   = state_d == WRITE;
    busy_d = !(state_d inside {IDLE, DONE, ERR});
    done_d = state_d == DONE;
    err_d  = state_d == ERR;
    hold_d = state_d != DONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
      wl_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      csum_q  <= csum_d;
      wl_q    <= wl_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mw_q    <= mw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven and randomized checks of program_loader at BASE_ADDR 0 and 0xFF
module tb_program_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic rdy0, mw0, h0, b0, dn0, er0, rdy1, mw1, h1, b1, dn1, er1;
  logic [7:0] a0, a1;
  logic [15:0] d0, d1;
  logic [8:0] wl0, wl1;
  int checks = 0;
  int failures = 0;
  logic [23:0] log0[$];
  logic [23:0] log1[$];

  always #5 clk = ~clk;

  program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy0), .mem_addr(a0), .mem_data(d0), .mem_write(mw0), .cpu_hold(h0),
    .busy(b0), .done(dn0), .error(er0), .words_loaded(wl0));
  program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(255)) u1 (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy1), .mem_addr(a1), .mem_data(d1), .mem_write(mw1), .cpu_hold(h1),
    .busy(b1), .done(dn1), .error(er1), .words_loaded(wl1));

  always @(negedge clk) begin
    if (mw0) log0.push_back({a0, d0});
    if (mw1) log1.push_back({a1, d1});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // reference: decode the image purely from the stream format rules
  task automatic model(input logic [7:0] q[$], output logic ok, output logic bad,
                       output int words, output logic [15:0] wd[$]);
    int len, sum;
    wd.delete();
    len = {q[0], q[1]};
    sum = q[0] + q[1];
    words = 0;
    ok = 1'b0;
    bad = 1'b1;
    if (len == 0 || len > 256) return;
    for (int i = 0; i < len; i++) begin
      wd.push_back({q[2+2*i], q[3+2*i]});
      sum += q[2+2*i] + q[3+2*i];
    end
    words = len;
    ok = (q[2+2*len] == 8'(sum % 256));
    bad = !ok;
  endtask

  task automatic pulse_start();
    rx_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
      repeat (gap) @(negedge clk);
    end
    rx_data = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      if (rdy0) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("rx_ready_timeout", 0, 1);
  endtask

  task automatic run_load(input string tag, input logic [7:0] q[$], input int gapmax, input int start_at);
    logic ok, bad;
    int words;
    logic [15:0] wd[$];
    log0.delete();
    log1.delete();
    pulse_start();
    chk({tag, "_busy_after_start"}, b0, 1);
    chk({tag, "_done_after_start"}, dn0, 0);
    chk({tag, "_hold_after_start"}, h0, 1);
    chk({tag, "_wl_after_start"}, wl0, 0);
    for (int i = 0; i < q.size(); i++) begin
      if (i == start_at) pulse_start();
      send(q[i], $urandom_range(0, gapmax));
    end
    rx_valid = 1'b0;
    model(q, ok, bad, words, wd);
    chk({tag, "_done"}, dn0, ok);
    chk({tag, "_error"}, er0, bad);
    chk({tag, "_cpu_hold"}, h0, !ok);
    chk({tag, "_busy"}, b0, 0);
    chk({tag, "_words_loaded"}, wl0, words);
    chk({tag, "_done_b255"}, dn1, ok);
    chk({tag, "_words_b255"}, wl1, words);
    chk({tag, "_nwrites_b0"}, log0.size(), wd.size());
    chk({tag, "_nwrites_b255"}, log1.size(), wd.size());
    for (int i = 0; i < wd.size() && i < log0.size() && i < log1.size(); i++) begin
      chk({tag, "_write_b0"}, log0[i], {8'(i), wd[i]});
      chk({tag, "_write_b255"}, log1[i], {8'(255 + i), wd[i]});
    end
    if (wd.size() > 0) begin
      chk({tag, "_addr_hold"}, a0, 8'(wd.size() - 1));
      chk({tag, "_data_hold"}, d0, wd[wd.size()-1]);
    end
  endtask

  typedef struct {
    int n;
    logic [7:0] b[8];
    int sa;
    logic exp_done;
    logic exp_err;
    int exp_words;
  } vec_t;

  vec_t vec[6];

  initial begin
    logic [7:0] q[$];
    vec[0] = '{7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0, 8'h00}, -1, 1'b1, 1'b0, 2};
    vec[1] = '{7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1, 8'h00}, -1, 1'b0, 1'b1, 2};
    vec[2] = '{2, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 1'b0, 1'b1, 0};
    vec[3] = '{2, '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 1'b0, 1'b1, 0};
    vec[4] = '{5, '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00}, -1, 1'b1, 1'b0, 1};
    vec[5] = '{7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0, 8'h00}, 4, 1'b1, 1'b0, 2};

    repeat (3) @(negedge clk);
    chk("rst_rx_ready", rdy0, 0);
    chk("rst_mem_write", mw0, 0);
    chk("rst_cpu_hold", h0, 1);
    chk("rst_busy", b0, 0);
    chk("rst_done", dn0, 0);
    chk("rst_error", er0, 0);
    chk("rst_words", wl0, 0);
    chk("rst_addr", a1, 0);
    chk("rst_data", d0, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      q.delete();
      for (int i = 0; i < vec[v].n; i++) q.push_back(vec[v].b[i]);
      run_load($sformatf("vec%0d", v), q, v % 3, vec[v].sa);
      chk($sformatf("vec%0d_tbl_done", v), dn0, vec[v].exp_done);
      chk($sformatf("vec%0d_tbl_error", v), er0, vec[v].exp_err);
      chk($sformatf("vec%0d_tbl_words", v), wl0, vec[v].exp_words);
    end

    for (int r = 0; r < 20; r++) begin
      int len, sum;
      logic valid;
      q.delete();
      case ($urandom_range(0, 9))
        0: len = 0;
        1: len = 257;
        2: len = 16'hFFFF;
        default: len = $urandom_range(1, 6);
      endcase
      valid = (len >= 1 && len <= 256);
      q.push_back(8'(len >> 8));
      q.push_back(8'(len));
      sum = q[0] + q[1];
      if (valid) begin
        for (int i = 0; i < 2 * len; i++) begin
          q.push_back(8'($urandom));
          sum += q[q.size()-1];
        end
        q.push_back(8'(sum % 256 + ($urandom_range(0, 3) == 0 ? 1 : 0)));
      end
      run_load($sformatf("rnd%0d", r), q, 3, -1);
    end

    // reset while a load is mid-word with a byte waiting
    q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    run_load("pre_reset", q, 0, -1);
    log0.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) send(q[i], 0);
    rx_data = 8'hCD;
    rx_valid = 1'b1;
    reset = 1'b0;
    #1;
    chk("midrst_rx_ready", rdy0, 0);
    chk("midrst_mem_write", mw0, 0);
    chk("midrst_cpu_hold", h0, 1);
    chk("midrst_done", dn0, 0);
    chk("midrst_error", er0, 0);
    chk("midrst_busy", b0, 0);
    chk("midrst_words", wl0, 0);
    chk("midrst_writes_before", log0.size(), 1);
    @(negedge clk);
    chk("midrst_hold_held", h0, 1);
    chk("midrst_no_write", mw0, 0);
    reset = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    run_load("post_reset", q, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
